// File: rtl/run_monitor_pkg.sv
// Shared types and defaults for the run monitor: FSM state encoding and
// the default counter width / drain budget.
package run_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int CNT_W_DEF     = 32;
  localparam int DRAIN_MAX_DEF = 16;

endpackage

// File: rtl/run_monitor_sat_counter.sv
// Clear/enable counter that sticks at all-ones instead of wrapping.
// Clear has priority over enable.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  // Count register: clear, else increment while enabled and not yet saturated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/run_monitor.sv
// Run monitor: tracks one program run (IDLE -> RUN -> DRAIN -> DONE),
// counting active cycles and retired instructions, and raises a clean
// registered end-of-run flag for the statistics printer.
module run_monitor
  import run_monitor_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEF,
  parameter int DRAIN_MAX = DRAIN_MAX_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             instr_valid,
  input  logic             halt,
  input  logic             pipeline_empty,
  output logic             stat_control,
  output logic [CNT_W-1:0] number_instructions,
  output logic [CNT_W-1:0] number_cycles,
  output logic             running,
  output logic             drain_timeout
);

  localparam int            DW         = $clog2(DRAIN_MAX + 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_MAX - 1);

  state_t        state_r;
  state_t        state_s;
  logic [DW-1:0] drain_cnt_r;
  logic [DW-1:0] drain_cnt_s;
  logic          clr_s;
  logic          set_timeout_s;
  logic          active_s;

  // Counters advance on every edge spent in RUN or DRAIN.
  assign active_s = (state_r == ST_RUN) || (state_r == ST_DRAIN);

  // Next-state logic; pipeline_empty is tested before the drain budget so it
  // wins when both happen on the same edge.
  always_comb begin
    state_s       = state_r;
    drain_cnt_s   = drain_cnt_r;
    clr_s         = 1'b0;
    set_timeout_s = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_s = ST_RUN;
          clr_s   = 1'b1;
        end else begin
          state_s = state_r;
        end
      end
      ST_RUN: begin
        drain_cnt_s = '0;
        if (halt) begin
          state_s = ST_DRAIN;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (pipeline_empty) begin
          state_s     = ST_DONE;
          drain_cnt_s = '0;
        end else if (drain_cnt_r == DRAIN_LAST) begin
          state_s       = ST_DONE;
          drain_cnt_s   = '0;
          set_timeout_s = 1'b1;
        end else begin
          drain_cnt_s = drain_cnt_r + DW'(1);
        end
      end
      default: begin
        state_s     = ST_IDLE;
        drain_cnt_s = '0;
      end
    endcase
  end

  // State, drain counter and registered status flags derived from next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      drain_cnt_r   <= '0;
      stat_control  <= 1'b0;
      running       <= 1'b0;
      drain_timeout <= 1'b0;
    end else begin
      state_r      <= state_s;
      drain_cnt_r  <= drain_cnt_s;
      stat_control <= (state_s == ST_DONE);
      running      <= (state_s == ST_RUN) || (state_s == ST_DRAIN);
      if (clr_s) begin
        drain_timeout <= 1'b0;
      end else if (set_timeout_s) begin
        drain_timeout <= 1'b1;
      end else begin
        drain_timeout <= drain_timeout;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_cycles (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr_s),
    .en    (active_s),
    .count (number_cycles)
  );

  sat_counter #(.W(CNT_W)) u_instrs (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr_s),
    .en    (active_s && instr_valid),
    .count (number_instructions)
  );

endmodule
